// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locking arbiter sharing one uart_tx serializer
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int N_DATA_BITS  = 8,
    parameter int HOLD_TIMEOUT = 255
) (
    input  logic                           i_uart_clk,
    input  logic                           i_uart_reset_n,
    input  logic [N_REQ-1:0]               i_req_valid,
    input  logic [N_REQ*N_DATA_BITS-1:0]   i_req_data,
    input  logic [N_REQ-1:0]               i_req_last,
    output logic [N_REQ-1:0]               o_req_ready,
    output logic [N_REQ-1:0]               o_grant,
    input  logic                           i_tx_ready,
    output logic                           o_tx_data_valid,
    output logic [N_DATA_BITS-1:0]         o_tx_data,
    output logic                           o_busy,
    output logic                           o_timeout
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] HOLD_LAST = TW'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);
    localparam logic [IW:0]   N_REQ_W   = (IW+1)'(N_REQ);

    typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_DRAIN} state_t;

    state_t                 state;
    logic [IW-1:0]          owner;
    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          win_idx;
    logic [IW-1:0]          next_ptr;
    logic [IW:0]            sum;
    logic                   win_found;
    logic                   last_flag;
    logic [TW-1:0]          hold_cnt;
    logic                   can_load;
    logic                   accept;
    logic                   drain;
    logic                   sel_valid;
    logic                   sel_last;
    logic [N_DATA_BITS-1:0] sel_data;

    // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        sum       = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(i);
            if (sum >= N_REQ_W) begin
                sum = sum - N_REQ_W;
            end
            if (i_req_valid[sum[IW-1:0]]) begin
                win_idx   = sum[IW-1:0];
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (owner == IW'(k)) begin
                sel_data  = i_req_data[k*N_DATA_BITS +: N_DATA_BITS];
                sel_valid = i_req_valid[k];
                sel_last  = i_req_last[k];
            end
        end
    end

    assign next_ptr    = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
    assign can_load    = ~o_tx_data_valid | i_tx_ready;
    assign o_req_ready = (state == ST_OWN) ? (o_grant & {N_REQ{can_load}}) : '0;
    assign accept      = (state == ST_OWN) & can_load & sel_valid;
    assign drain       = o_tx_data_valid & i_tx_ready;
    assign o_busy      = (state != ST_IDLE) | o_tx_data_valid;

    always_ff @(posedge i_uart_clk or negedge i_uart_reset_n) begin
        if (!i_uart_reset_n) begin
            state           <= ST_IDLE;
            owner           <= '0;
            rr_ptr          <= '0;
            o_grant         <= '0;
            o_tx_data_valid <= 1'b0;
            o_tx_data       <= '0;
            last_flag       <= 1'b0;
            hold_cnt        <= '0;
            o_timeout       <= 1'b0;
        end else begin
            o_timeout <= 1'b0;

            // A drain and a reload on the same edge keep valid high with no bubble.
            if (accept) begin
                o_tx_data       <= sel_data;
                o_tx_data_valid <= 1'b1;
                last_flag       <= sel_last;
            end else if (drain) begin
                o_tx_data_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    hold_cnt <= '0;
                    if (win_found) begin
                        owner   <= win_idx;
                        o_grant <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                        state   <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (accept) begin
                        hold_cnt <= '0;
                        if (sel_last) begin
                            state <= ST_DRAIN;
                        end
                    end else if ((HOLD_TIMEOUT != 0) && !o_tx_data_valid && !sel_valid) begin
                        if (hold_cnt == HOLD_LAST) begin
                            o_timeout <= 1'b1;
                            o_grant   <= '0;
                            rr_ptr    <= next_ptr;
                            hold_cnt  <= '0;
                            state     <= ST_IDLE;
                        end else begin
                            hold_cnt <= hold_cnt + TW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain && last_flag) begin
                        o_grant <= '0;
                        rr_ptr  <= next_ptr;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
